mem_access_initiator: RTL and testbench
=======================================

Name: mem_access_initiator

Overview:
- Initiator end of the word-addressed SRAM memory interface. Turns byte-addressed load/store requests from the core (byte/half/word, signed/unsigned) into word requests with byte enables on the memory port.
- Waits for the responder's acks, then returns extracted, extended load data or store completion to the core.
- Splits misaligned accesses into two word accesses.
- Detects lost acks (timeout) and read-address mismatches.

Parameters:
- TIMEOUT_CYCLES, 16: cycles after issue without a matching ack before abort; minimum 4.
- SPLIT_MISALIGNED, 1: 1 = split a word-crossing access into two accesses; 0 = error response with no memory traffic.

Ports:
- clk  in  1  clock.
- sync_reset  in  1  synchronous, active-high reset.
- req_valid  in  1  core request valid.
- req_ready  out  1  high only in IDLE (combinational from state).
- req_write  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_size  in  2  0 = byte, 1 = half, 2 = word; 3 is treated as word.
- req_unsigned  in  1  zero-extend loads when set.
- req_wdata  in  XLEN  store data, right-justified.
- resp_valid  out  1  one-cycle completion pulse.
- resp_error  out  1  qualified by resp_valid.
- resp_rdata  out  XLEN  load result; 0 for stores and errors.
- mem_addr  out  MEM_ADDR_BITS  word address.
- mem_read_en  out  1  one-cycle read pulse.
- mem_write_en  out  XLEN_BYTES  byte write enables, one-cycle pulse.
- mem_write_data  out  XLEN  lane-aligned write data.
- mem_read_data  in  XLEN  responder data, valid with mem_read_ack.
- mem_read_ack  in  1  read completion.
- mem_write_ack  in  1  write completion.
- mem_addr_ack  in  MEM_ADDR_BITS  word address of the completed read.

Behaviour:
- Reset: a cycle with sync_reset high forces the following values from the next cycle on:
  - state IDLE, phase 0, timeout counter 0;
  - mem_read_en 0, mem_write_en 0, mem_addr 0, mem_write_data 0;
  - resp_valid 0, resp_error 0, resp_rdata 0;
  - req_ready 1.
  Reset mid-transaction abandons it with no resp_valid. Acks arriving after reset are ignored.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - req_valid & req_ready at a clock edge latches the request.
  - Computes byte offset off = req_addr[1:0] and mask = {1,3,F}[size] << off (8 bits).
  - Computes shifted data = req_wdata << 8*off (64 bits).
  - Split needed iff mask[7:4] != 0.
  - Split needed with SPLIT_MISALIGNED=0: go to RESP with error.
  - Otherwise go to ISSUE, phase 0.
- ISSUE (exactly one cycle):
  - Phase 0: mem_addr = req_addr[MEM_ADDR_BITS+1:2], byte lanes mask[3:0], data bits [31:0].
  - Phase 1: mem_addr = that value + 1 (wraps modulo 2^MEM_ADDR_BITS), lanes mask[7:4], data bits [63:32].
  - Loads pulse mem_read_en; stores pulse mem_write_en with the lane mask.
  - All memory outputs return to 0 the next cycle.
  - Timeout counter cleared. Next state WAIT.
- WAIT:
  - Counts cycles. Only the ack matching the operation counts; the other ack type is ignored.
  - Read ack: capture mem_read_data into word[phase].
  - Read ack with mem_addr_ack != issued mem_addr: sticky error flag set; data is still captured.
  - Ack with split and phase 0: set phase 1, go to ISSUE. Otherwise go to RESP.
  - Counter reaching TIMEOUT_CYCLES without an ack: error, go to RESP.
  - An ack and timeout in the same cycle: the ack wins.
- RESP (one cycle):
  - resp_valid = 1 and resp_error = flag.
  - Load without error: resp_rdata = ({word1, word0} >> 8*off) truncated to size, then sign- or zero-extended.
  - Otherwise resp_rdata = 0.
  - Next state IDLE.
- Acks seen in IDLE, ISSUE or RESP are ignored.
- Timing against the SRAM responder (read ack 3 cycles after mem_read_en; write ack 1 cycle after write_en), request accepted in cycle 0:
  - Aligned store: write_en cycle 1, ack cycle 2, resp_valid cycle 3.
  - Aligned load: read_en cycle 1, ack cycle 4, resp_valid cycle 5.
  - Split load: second read_en cycle 5, resp_valid cycle 9.
  - Split store: resp_valid cycle 5.
- At most one outstanding memory request at any time; no back-to-back issue.

Decomposition:
- Shared package:
  - size encodings (SIZE_BYTE/HALF/WORD);
  - state enum;
  - lane-mask constants.
- One natural sub-module, mem_lane_align (combinational): store shift/mask generation and load extract/extend.
- The FSM, counter and registers stay in the top module.

Test Plan:
- Store word 0xDEADBEEF to 0x100 -> cycle 1: mem_addr 0x40, mem_write_en 4'hF, mem_write_data 0xDEADBEEF; resp_valid cycle 3, resp_error 0.
- Load byte from 0x103, word 0x40 = 0x80112233 -> signed resp_rdata 0xFFFFFF80, unsigned 0x00000080, resp_valid cycle 5.
- Load word from 0x102, memory 0x40 = 0xAABBCCDD, 0x41 = 0x11223344 -> reads at 0x40 then 0x41; resp_rdata 0x3344AABB, resp_valid cycle 9.
- Store half 0xBEEF to 0x103 -> write 0x40, en 4'b1000, data 0xEF000000; then write 0x41, en 4'b0001, data 0x000000BE; one resp_valid. With SPLIT_MISALIGNED=0: no write enables, resp_error 1.
- Load from a model that never acks (TIMEOUT 16) -> resp_valid with resp_error 1 and rdata 0 at cycle 18; req_ready 1 the next cycle. A read ack carrying a wrong mem_addr_ack also gives resp_error 1.
- sync_reset in WAIT, then a late ack -> no resp_valid, memory outputs 0; the next aligned load completes normally in 5 cycles.

Source files
------------

// File: rtl/mem_access_initiator_pkg.sv
// Shared types and constants for the memory access initiator and its lane aligner.
package mem_access_initiator_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned XLEN_BYTES = XLEN / 8;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  localparam logic [7:0] LANE_MASK_BYTE = 8'h01;
  localparam logic [7:0] LANE_MASK_HALF = 8'h03;
  localparam logic [7:0] LANE_MASK_WORD = 8'h0F;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StResp
  } state_e;

  // Size code 3 behaves as a word access.
  function automatic logic [7:0] size_mask(input logic [1:0] size);
    case (size)
      SIZE_BYTE: size_mask = LANE_MASK_BYTE;
      SIZE_HALF: size_mask = LANE_MASK_HALF;
      default:   size_mask = LANE_MASK_WORD;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_initiator_lane_align.sv
// Combinational lane alignment: store mask/data shifting and load extract/extend
// across a two-word window.
module mem_lane_align
  import mem_access_initiator_pkg::*;
(
  input  logic [1:0]        st_size_i,
  input  logic [1:0]        st_off_i,
  input  logic [XLEN-1:0]   st_wdata_i,
  output logic [7:0]        st_mask_o,
  output logic [2*XLEN-1:0] st_data_o,
  input  logic [1:0]        ld_size_i,
  input  logic [1:0]        ld_off_i,
  input  logic              ld_unsigned_i,
  input  logic [2*XLEN-1:0] ld_data_i,
  output logic [XLEN-1:0]   ld_result_o
);

  logic [2*XLEN-1:0] ld_shifted;
  logic              sign_ext;

  always_comb begin
    st_mask_o   = size_mask(st_size_i) << st_off_i;
    st_data_o   = {{XLEN{1'b0}}, st_wdata_i} << {st_off_i, 3'b000};
    ld_shifted  = ld_data_i >> {ld_off_i, 3'b000};
    sign_ext    = !ld_unsigned_i;
    ld_result_o = '0;
    case (ld_size_i)
      SIZE_BYTE: ld_result_o = {{(XLEN-8){sign_ext & ld_shifted[7]}}, ld_shifted[7:0]};
      SIZE_HALF: ld_result_o = {{(XLEN-16){sign_ext & ld_shifted[15]}}, ld_shifted[15:0]};
      default:   ld_result_o = ld_shifted[XLEN-1:0];
    endcase
  end

endmodule

// File: rtl/mem_access_initiator.sv
// Byte-addressed load/store front end for a word-addressed SRAM port; splits
// word-crossing accesses and flags lost or mismatched acks.
module mem_access_initiator
  import mem_access_initiator_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES   = 16,
  parameter bit          SPLIT_MISALIGNED = 1'b1,
  parameter int unsigned MEM_ADDR_BITS    = 16
) (
  input  logic                     clk,
  input  logic                     sync_reset,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_write,
  input  logic [31:0]              req_addr,
  input  logic [1:0]               req_size,
  input  logic                     req_unsigned,
  input  logic [XLEN-1:0]          req_wdata,
  output logic                     resp_valid,
  output logic                     resp_error,
  output logic [XLEN-1:0]          resp_rdata,
  output logic [MEM_ADDR_BITS-1:0] mem_addr,
  output logic                     mem_read_en,
  output logic [XLEN_BYTES-1:0]    mem_write_en,
  output logic [XLEN-1:0]          mem_write_data,
  input  logic [XLEN-1:0]          mem_read_data,
  input  logic                     mem_read_ack,
  input  logic                     mem_write_ack,
  input  logic [MEM_ADDR_BITS-1:0] mem_addr_ack
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CntW-1:0] TimeoutLast = CntW'(TIMEOUT_CYCLES - 1);

  state_e                   state_q, state_d;
  logic                     phase_q, phase_d;
  logic [CntW-1:0]          cnt_q, cnt_d;
  logic                     err_q, err_d;
  logic                     split_q, split_d;
  logic                     write_q, write_d;
  logic                     uns_q, uns_d;
  logic [1:0]               size_q, size_d;
  logic [1:0]               off_q, off_d;
  logic [MEM_ADDR_BITS-1:0] addr_q, addr_d;
  logic [7:0]               mask_q, mask_d;
  logic [2*XLEN-1:0]        wdata_q, wdata_d;
  logic [XLEN-1:0]          word0_q, word0_d;
  logic [XLEN-1:0]          word1_q, word1_d;

  logic [7:0]               st_mask;
  logic [2*XLEN-1:0]        st_data;
  logic [XLEN-1:0]          ld_result;
  logic                     st_split;
  logic                     wait_ack;
  logic [MEM_ADDR_BITS-1:0] issue_addr;
  logic                     unused_addr;

  assign unused_addr = ^req_addr[31:MEM_ADDR_BITS+2];
  assign st_split    = |st_mask[7:4];
  assign wait_ack    = write_q ? mem_write_ack : mem_read_ack;
  assign issue_addr  = phase_q ? addr_q + MEM_ADDR_BITS'(1) : addr_q;

  mem_lane_align u_lane_align (
    .st_size_i     (req_size),
    .st_off_i      (req_addr[1:0]),
    .st_wdata_i    (req_wdata),
    .st_mask_o     (st_mask),
    .st_data_o     (st_data),
    .ld_size_i     (size_q),
    .ld_off_i      (off_q),
    .ld_unsigned_i (uns_q),
    .ld_data_i     ({word1_q, word0_q}),
    .ld_result_o   (ld_result)
  );

  always_ff @(posedge clk) begin
    if (sync_reset) begin
      state_q <= StIdle;
      phase_q <= 1'b0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      split_q <= 1'b0;
      write_q <= 1'b0;
      uns_q   <= 1'b0;
      size_q  <= '0;
      off_q   <= '0;
      addr_q  <= '0;
      mask_q  <= '0;
      wdata_q <= '0;
      word0_q <= '0;
      word1_q <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      split_q <= split_d;
      write_q <= write_d;
      uns_q   <= uns_d;
      size_q  <= size_d;
      off_q   <= off_d;
      addr_q  <= addr_d;
      mask_q  <= mask_d;
      wdata_q <= wdata_d;
      word0_q <= word0_d;
      word1_q <= word1_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    phase_d        = phase_q;
    cnt_d          = cnt_q;
    err_d          = err_q;
    split_d        = split_q;
    write_d        = write_q;
    uns_d          = uns_q;
    size_d         = size_q;
    off_d          = off_q;
    addr_d         = addr_q;
    mask_d         = mask_q;
    wdata_d        = wdata_q;
    word0_d        = word0_q;
    word1_d        = word1_q;
    req_ready      = (state_q == StIdle);
    resp_valid     = 1'b0;
    resp_error     = 1'b0;
    resp_rdata     = '0;
    mem_addr       = '0;
    mem_read_en    = 1'b0;
    mem_write_en   = '0;
    mem_write_data = '0;

    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          write_d = req_write;
          uns_d   = req_unsigned;
          size_d  = req_size;
          off_d   = req_addr[1:0];
          addr_d  = req_addr[MEM_ADDR_BITS+1:2];
          mask_d  = st_mask;
          wdata_d = st_data;
          split_d = st_split;
          phase_d = 1'b0;
          cnt_d   = '0;
          err_d   = 1'b0;
          word0_d = '0;
          word1_d = '0;
          // Without splitting, a word-crossing access fails before touching memory.
          if (st_split && !SPLIT_MISALIGNED) begin
            err_d   = 1'b1;
            state_d = StResp;
          end else begin
            state_d = StIssue;
          end
        end
      end
      StIssue: begin
        mem_addr = issue_addr;
        if (write_q) begin
          mem_write_en   = phase_q ? mask_q[7:4] : mask_q[3:0];
          mem_write_data = phase_q ? wdata_q[2*XLEN-1:XLEN] : wdata_q[XLEN-1:0];
        end else begin
          mem_read_en = 1'b1;
        end
        cnt_d   = '0;
        state_d = StWait;
      end
      StWait: begin
        if (wait_ack) begin
          if (!write_q) begin
            if (phase_q) word1_d = mem_read_data;
            else         word0_d = mem_read_data;
            if (mem_addr_ack != issue_addr) err_d = 1'b1;
          end
          if (split_q && !phase_q) begin
            phase_d = 1'b1;
            state_d = StIssue;
          end else begin
            state_d = StResp;
          end
        end else if (cnt_q == TimeoutLast) begin
          err_d   = 1'b1;
          state_d = StResp;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StResp: begin
        resp_valid = 1'b1;
        resp_error = err_q;
        if (!write_q && !err_q) resp_rdata = ld_result;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

endmodule

// File: tb/tb_mem_access_initiator.sv
// Directed bench: SRAM responder model (read ack +3, write ack +1) and
// hand-computed expectations for aligned, split, error and reset cases.
module tb_mem_access_initiator;
  import mem_access_initiator_pkg::*;

  localparam int unsigned AW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          sync_reset, req_valid, req_valid1, req_write, req_unsigned;
  logic [31:0]   req_addr, req_wdata;
  logic [1:0]    req_size;

  logic          d0_ready, d0_rv, d0_re, d0_ren;
  logic [31:0]   d0_rd, d0_wd;
  logic [AW-1:0] d0_ma;
  logic [3:0]    d0_we;
  logic          d1_ready, d1_rv, d1_re, d1_ren;
  logic [31:0]   d1_rd, d1_wd;
  logic [AW-1:0] d1_ma;
  logic [3:0]    d1_we;

  logic [31:0]   mem_read_data;
  logic          mem_read_ack, mem_write_ack;
  logic [AW-1:0] mem_addr_ack;

  mem_access_initiator #(.TIMEOUT_CYCLES(16), .SPLIT_MISALIGNED(1'b1), .MEM_ADDR_BITS(AW)) dut (
    .clk(clk), .sync_reset(sync_reset), .req_valid(req_valid), .req_ready(d0_ready),
    .req_write(req_write), .req_addr(req_addr), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_wdata(req_wdata), .resp_valid(d0_rv),
    .resp_error(d0_re), .resp_rdata(d0_rd), .mem_addr(d0_ma), .mem_read_en(d0_ren),
    .mem_write_en(d0_we), .mem_write_data(d0_wd), .mem_read_data(mem_read_data),
    .mem_read_ack(mem_read_ack), .mem_write_ack(mem_write_ack), .mem_addr_ack(mem_addr_ack)
  );

  mem_access_initiator #(.TIMEOUT_CYCLES(16), .SPLIT_MISALIGNED(1'b0), .MEM_ADDR_BITS(AW)) dut_nosplit (
    .clk(clk), .sync_reset(sync_reset), .req_valid(req_valid1), .req_ready(d1_ready),
    .req_write(req_write), .req_addr(req_addr), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_wdata(req_wdata), .resp_valid(d1_rv),
    .resp_error(d1_re), .resp_rdata(d1_rd), .mem_addr(d1_ma), .mem_read_en(d1_ren),
    .mem_write_en(d1_we), .mem_write_data(d1_wd), .mem_read_data('0),
    .mem_read_ack(1'b0), .mem_write_ack(1'b0), .mem_addr_ack('0)
  );

  // Responder model
  logic [31:0]   mem [0:255];
  logic          no_ack, bad_addr, pre_en;
  logic [7:0]    pre_addr;
  logic [31:0]   pre_data;
  logic [2:0]    rd_v = '0;
  logic [AW-1:0] rd_a0, rd_a1, rd_a2;
  logic [31:0]   rd_d0, rd_d1, rd_d2;
  logic          wack = 1'b0;

  always @(posedge clk) begin
    rd_v  <= {rd_v[1:0], d0_ren & ~no_ack};
    rd_a0 <= d0_ma;
    rd_a1 <= rd_a0;
    rd_a2 <= rd_a1;
    rd_d0 <= mem[d0_ma[7:0]];
    rd_d1 <= rd_d0;
    rd_d2 <= rd_d1;
    wack  <= (|d0_we) & ~no_ack;
    for (int b = 0; b < 4; b++)
      if (d0_we[b]) mem[d0_ma[7:0]][8*b +: 8] <= d0_wd[8*b +: 8];
    if (pre_en) mem[pre_addr] <= pre_data;
  end

  assign mem_read_ack  = rd_v[2];
  assign mem_read_data = rd_d2;
  assign mem_addr_ack  = bad_addr ? rd_a2 + AW'(5) : rd_a2;
  assign mem_write_ack = wack;

  // Monitor selects which DUT is observed
  logic          sel;
  logic          m_ready, m_rv, m_re, m_ren;
  logic [31:0]   m_rd, m_wd;
  logic [AW-1:0] m_ma;
  logic [3:0]    m_we;
  assign m_ready = sel ? d1_ready : d0_ready;
  assign m_rv    = sel ? d1_rv    : d0_rv;
  assign m_re    = sel ? d1_re    : d0_re;
  assign m_rd    = sel ? d1_rd    : d0_rd;
  assign m_ren   = sel ? d1_ren   : d0_ren;
  assign m_wd    = sel ? d1_wd    : d0_wd;
  assign m_ma    = sel ? d1_ma    : d0_ma;
  assign m_we    = sel ? d1_we    : d0_we;

  int            n_checks = 0, n_fail = 0;
  int            resp_cnt, resp_cyc, rd_cnt, wr_cnt, late_busy;
  logic          resp_err;
  logic [31:0]   resp_data;
  int            rd_cyc [2];
  logic [AW-1:0] rd_ad [2];
  int            wr_cyc [2];
  logic [AW-1:0] wr_ad [2];
  logic [3:0]    wr_en [2];
  logic [31:0]   wr_dat [2];
  logic          ready_at [0:31];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    pre_en = 1'b1; pre_addr = a; pre_data = d;
    @(negedge clk);
    pre_en = 1'b0;
  endtask

  // Request accepted at the edge ending cycle 0; cycle c is sampled at its negedge.
  task automatic run(input logic wr, input logic [31:0] addr, input logic [1:0] size,
                     input logic uns, input logic [31:0] wd, input logic use1,
                     input int ncyc, input int rst_cyc);
    @(negedge clk);
    sel = use1; req_write = wr; req_addr = addr; req_size = size;
    req_unsigned = uns; req_wdata = wd;
    if (use1) req_valid1 = 1'b1; else req_valid = 1'b1;
    resp_cnt = 0; resp_cyc = -1; resp_err = 1'b0; resp_data = '0;
    rd_cnt = 0; wr_cnt = 0; late_busy = 0;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      if (c == 1) begin req_valid = 1'b0; req_valid1 = 1'b0; end
      if (rst_cyc != 0 && c == rst_cyc) sync_reset = 1'b1;
      if (rst_cyc != 0 && c == rst_cyc + 1) sync_reset = 1'b0;
      if (c < 32) ready_at[c] = m_ready;
      if (m_rv) begin
        if (resp_cnt == 0) begin resp_cyc = c; resp_err = m_re; resp_data = m_rd; end
        resp_cnt++;
      end
      if (m_ren) begin
        if (rd_cnt < 2) begin rd_cyc[rd_cnt] = c; rd_ad[rd_cnt] = m_ma; end
        rd_cnt++;
      end
      if (|m_we) begin
        if (wr_cnt < 2) begin
          wr_cyc[wr_cnt] = c; wr_ad[wr_cnt] = m_ma; wr_en[wr_cnt] = m_we; wr_dat[wr_cnt] = m_wd;
        end
        wr_cnt++;
      end
      if (rst_cyc != 0 && c > rst_cyc && (m_ren || |m_we || m_ma != '0 || m_wd != '0))
        late_busy++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    sync_reset = 1'b1; req_valid = 1'b0; req_valid1 = 1'b0; req_write = 1'b0;
    req_addr = '0; req_size = '0; req_unsigned = 1'b0; req_wdata = '0;
    no_ack = 1'b0; bad_addr = 1'b0; pre_en = 1'b0; pre_addr = '0; pre_data = '0; sel = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst_ready", d0_ready, 1);
    chk("rst_resp_valid", d0_rv, 0);
    chk("rst_resp_rdata", d0_rd, 0);
    chk("rst_read_en", d0_ren, 0);
    chk("rst_write_en", d0_we, 0);
    chk("rst_mem_addr", d0_ma, 0);
    chk("rst_wdata", d0_wd, 0);
    chk("rst_ready_nosplit", d1_ready, 1);
    sync_reset = 1'b0;

    // Aligned store word
    run(1'b1, 32'h100, SIZE_WORD, 1'b0, 32'hDEADBEEF, 1'b0, 8, 0);
    chk("st_w_count", wr_cnt, 1);
    chk("st_w_cycle", wr_cyc[0], 1);
    chk("st_w_addr", wr_ad[0], 16'h40);
    chk("st_w_en", wr_en[0], 4'hF);
    chk("st_w_data", wr_dat[0], 32'hDEADBEEF);
    chk("st_w_resp_cyc", resp_cyc, 3);
    chk("st_w_resp_err", resp_err, 0);
    chk("st_w_resp_cnt", resp_cnt, 1);

    // Byte loads, signed and unsigned
    preload(8'h40, 32'h80112233);
    run(1'b0, 32'h103, SIZE_BYTE, 1'b0, '0, 1'b0, 8, 0);
    chk("ld_b_rd_cycle", rd_cyc[0], 1);
    chk("ld_b_rd_addr", rd_ad[0], 16'h40);
    chk("ld_b_resp_cyc", resp_cyc, 5);
    chk("ld_b_signed", resp_data, 32'hFFFFFF80);
    chk("ld_b_err", resp_err, 0);
    run(1'b0, 32'h103, SIZE_BYTE, 1'b1, '0, 1'b0, 8, 0);
    chk("ld_bu_data", resp_data, 32'h00000080);

    // Split word load
    preload(8'h40, 32'hAABBCCDD);
    preload(8'h41, 32'h11223344);
    run(1'b0, 32'h102, SIZE_WORD, 1'b0, '0, 1'b0, 12, 0);
    chk("ld_split_rd_cnt", rd_cnt, 2);
    chk("ld_split_addr0", rd_ad[0], 16'h40);
    chk("ld_split_addr1", rd_ad[1], 16'h41);
    chk("ld_split_rd1_cyc", rd_cyc[1], 5);
    chk("ld_split_resp_cyc", resp_cyc, 9);
    chk("ld_split_resp_cnt", resp_cnt, 1);
    chk("ld_split_data", resp_data, 32'h3344AABB);

    // Split half store
    run(1'b1, 32'h103, SIZE_HALF, 1'b0, 32'h0000BEEF, 1'b0, 8, 0);
    chk("st_split_wr_cnt", wr_cnt, 2);
    chk("st_split_addr0", wr_ad[0], 16'h40);
    chk("st_split_en0", wr_en[0], 4'b1000);
    chk("st_split_data0", wr_dat[0], 32'hEF000000);
    chk("st_split_addr1", wr_ad[1], 16'h41);
    chk("st_split_en1", wr_en[1], 4'b0001);
    chk("st_split_data1", wr_dat[1], 32'h000000BE);
    chk("st_split_wr1_cyc", wr_cyc[1], 3);
    chk("st_split_resp_cyc", resp_cyc, 5);
    chk("st_split_resp_cnt", resp_cnt, 1);

    // Read back what the split store left in memory
    run(1'b0, 32'h102, SIZE_HALF, 1'b0, '0, 1'b0, 8, 0);
    chk("ld_h_signed", resp_data, 32'hFFFFEFBB);
    run(1'b0, 32'h104, SIZE_BYTE, 1'b1, '0, 1'b0, 8, 0);
    chk("ld_bu_word41", resp_data, 32'h000000BE);

    // No-split instance rejects the word-crossing store
    run(1'b1, 32'h103, SIZE_HALF, 1'b0, 32'h0000BEEF, 1'b1, 4, 0);
    chk("nosplit_wr_cnt", wr_cnt, 0);
    chk("nosplit_resp_cnt", resp_cnt, 1);
    chk("nosplit_resp_cyc", resp_cyc, 1);
    chk("nosplit_err", resp_err, 1);

    // Lost ack times out
    no_ack = 1'b1;
    run(1'b0, 32'h200, SIZE_WORD, 1'b0, '0, 1'b0, 22, 0);
    no_ack = 1'b0;
    chk("timeout_resp_cyc", resp_cyc, 18);
    chk("timeout_err", resp_err, 1);
    chk("timeout_rdata", resp_data, 0);
    chk("timeout_ready_after", ready_at[19], 1);
    chk("timeout_resp_cnt", resp_cnt, 1);

    // Read ack with a wrong address
    bad_addr = 1'b1;
    run(1'b0, 32'h100, SIZE_WORD, 1'b0, '0, 1'b0, 8, 0);
    bad_addr = 1'b0;
    chk("badaddr_resp_cyc", resp_cyc, 5);
    chk("badaddr_err", resp_err, 1);
    chk("badaddr_rdata", resp_data, 0);

    // Reset during WAIT, late ack ignored
    run(1'b0, 32'h100, SIZE_WORD, 1'b0, '0, 1'b0, 10, 2);
    chk("rst_wait_resp_cnt", resp_cnt, 0);
    chk("rst_wait_mem_idle", late_busy, 0);
    chk("rst_wait_ready", ready_at[3], 1);
    chk("rst_wait_rd_cnt", rd_cnt, 1);

    run(1'b0, 32'h100, SIZE_WORD, 1'b0, '0, 1'b0, 8, 0);
    chk("post_rst_resp_cyc", resp_cyc, 5);
    chk("post_rst_data", resp_data, 32'hEFBBCCDD);
    chk("post_rst_err", resp_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
